uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous 8N1-style serial line into parallel bytes, using the 16x oversampling tick from `uart_baud_rate_generator` as its time base. It sits directly downstream of the baud rate generator and upstream of any byte consumer (FIFO, command parser) through a valid/ready handshake. It provides start-bit glitch rejection, mid-bit sampling, frame-error and overrun reporting, and an 8-bit `status` code matching the state encoding used by the rest of the UART blocks.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART blocks (receiver and transmitter):
//   - uart_state_e : FSM state encoding, also driven out as the 8-bit status code
//   - MID_TICK     : 16x tick index of the start-bit midpoint
//   - LAST_TICK    : 16x tick index that ends a bit period
//   - uart_frame_t : frame-format descriptor used by the TX side
//   - parity_bit() : parity bit for a data word, even or odd sense
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [7:0] {
    ST_IDLE       = 8'd1,
    ST_START      = 8'd2,
    ST_DATA       = 8'd3,
    ST_PARITY     = 8'd4,
    ST_STOP       = 8'd5,
    ST_BREAK_WAIT = 8'd6,
    ST_DONE       = 8'd255
  } uart_state_e;

  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'd15;

  typedef struct packed {
    logic [3:0] data_bits;   // 5..8
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
  } uart_frame_t;

  // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//
// Multi-stage synchroniser for the asynchronous serial line.
//   main_clk : system clock
//   areset   : asynchronous active-high reset
//   rx_i     : raw asynchronous serial input
//   rx_o     : synchronised serial line
// Parameter SYNC_STAGES (>= 2) sets the number of flip-flop stages.
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic main_clk,
  input  logic areset,
  input  logic rx_i,
  output logic rx_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: stages reset to 1 (idle line level) so leaving reset cannot look like
  // a falling start edge.
  always_ff @(posedge main_clk or posedge areset) begin
    if (areset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// 16x-oversampled UART receiver (start, DATA_BITS data LSB first, optional
// parity, one stop bit) with valid/ready output handshake.
//   main_clk    : system clock
//   areset      : asynchronous active-high reset
//   enable      : registered; allows a new frame to start (checked in IDLE only)
//   tick_16x    : one-cycle pulse at 16x the baud rate
//   rx          : asynchronous serial line, idle high
//   rx_ready    : consumer accepts rx_data
//   rx_data     : received word, right-aligned
//   rx_valid    : rx_data / frame_err / parity_err are valid
//   frame_err   : stop bit sampled low (held with rx_data)
//   parity_err  : parity mismatch (held with rx_data), 0 without parity
//   overrun_err : one-cycle pulse when an unconsumed word is overwritten
//   busy        : FSM not in IDLE
//   status      : current state code
// Compile-time option: define UART_RX_PARITY_EN to add the parity bit.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 main_clk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic                 tick_16x,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy,
  output logic [7:0]           status
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  uart_state_e          state_q, state_d;
  logic                 rx_s;
  logic                 enable_q;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_bit_q, stop_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 counting, mid_tick, last_tick;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .main_clk (main_clk),
    .areset   (areset),
    .rx_i     (rx),
    .rx_o     (rx_s)
  );

  assign counting  = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign mid_tick  = tick_16x && (tick_cnt_q == MID_TICK);
  assign last_tick = tick_16x && (tick_cnt_q == LAST_TICK);

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge main_clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (enable_q && !rx_s) state_d = ST_START;
      ST_START:      if (mid_tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (last_tick && (bit_cnt_q == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:     if (last_tick) state_d = ST_STOP;
`endif
      ST_STOP:       if (last_tick) state_d = ST_DONE;
      ST_DONE:       state_d = stop_bit_q ? ST_IDLE : ST_BREAK_WAIT;
      // Hold off until the line returns high so a break cannot start frames.
      ST_BREAK_WAIT: if (rx_s) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath / outputs
`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop_bit_d  = stop_bit_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = parity_err_q;
`endif

    if (state_d != state_q) begin
      tick_cnt_d = '0;
    end else if (counting && tick_16x) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end

    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
    end

    // Right shift: the first (LSB) bit ends up at bit 0 after DATA_BITS shifts.
    if ((state_q == ST_DATA) && last_tick) begin
      shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

`ifdef UART_RX_PARITY_EN
    if ((state_q == ST_PARITY) && last_tick) begin
      par_err_d = rx_s ^ parity_bit(8'(shift_q), PAR_ODD);
    end
`endif

    if ((state_q == ST_STOP) && last_tick) begin
      stop_bit_d = rx_s;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // A new word always loads; it only counts as an overrun if the old one
    // is still pending and not being taken on this same edge.
    if (state_q == ST_DONE) begin
      rx_data_d   = shift_q;
      frame_err_d = ~stop_bit_q;
      rx_valid_d  = 1'b1;
      overrun_d   = rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err_d = par_err_q;
`endif
    end
  end

  always_ff @(posedge main_clk or posedge areset) begin
    if (areset) begin
      enable_q    <= 1'b0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      stop_bit_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      enable_q    <= enable;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      stop_bit_q  <= stop_bit_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != ST_IDLE);
  assign status      = state_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PAR_ODD;
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. The 16x tick is produced locally every
// TICK_DIV clocks (a compressed baud rate). Expected words are queued when a
// frame is driven and compared when the consumer accepts rx_data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int PARITY_ODD  = 0;
  localparam int TICK_DIV    = 4;

  logic       main_clk = 1'b0;
  logic       areset;
  logic       enable;
  logic       tick_16x = 1'b0;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       busy;
  logic [7:0] status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       sb_q[$];
  int         valid_cycles = 0;
  int         overrun_cnt  = 0;
  logic       rec_en       = 1'b0;
  logic [7:0] status_log[$];
  int         tick_div_cnt = 0;

  uart_rx #(
    .DATA_BITS   (DATA_BITS),
    .SYNC_STAGES (SYNC_STAGES),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .main_clk    (main_clk),
    .areset      (areset),
    .enable      (enable),
    .tick_16x    (tick_16x),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .status      (status)
  );

  always #5 main_clk = ~main_clk;

  // Tick changes on the falling edge so it is stable at each rising edge.
  always @(negedge main_clk) begin
    tick_16x     = (tick_div_cnt == 0);
    tick_div_cnt = (tick_div_cnt + 1) % TICK_DIV;
  end

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge main_clk) begin
    exp_t e;
    if (!areset) begin
      if (rx_valid) valid_cycles++;
      if (overrun_err) begin
        overrun_cnt++;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h, required no word", rx_data);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (rx_data !== e.data) begin
            errors++;
            $display("FAIL rx_data: got %h, required %h", rx_data, e.data);
          end
          checks++;
          if (frame_err !== e.fe) begin
            errors++;
            $display("FAIL frame_err: got %b, required %b (data %h)", frame_err, e.fe, e.data);
          end
          checks++;
          if (parity_err !== e.pe) begin
            errors++;
            $display("FAIL parity_err: got %b, required %b (data %h)", parity_err, e.pe, e.data);
          end
        end
      end
      if (rec_en && (status_log.size() == 0 || status_log[status_log.size()-1] != status))
        status_log.push_back(status);
    end
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic wait_tick();
    do @(posedge main_clk); while (tick_16x !== 1'b1);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  function automatic logic exp_par(input logic [7:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Start bit, data LSB first, optional parity, stop bit; line left at stop level.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge main_clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    areset   = 1'b1;
    enable   = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge main_clk);
    #1;
    checks++;
    if (status !== 8'd1) begin errors++; $display("FAIL reset_status: got %0d, required 1", status); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    checks++;
    if ({rx_valid, frame_err, parity_err, overrun_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {rx_valid, frame_err, parity_err, overrun_err, busy});
    end
    areset = 1'b0;
    repeat (4) @(posedge main_clk);
    #1;
  endtask

  task automatic test_basic();
    int   v0;
    logic [7:0] exp_seq[$];
    logic bad;
    string s;
`ifdef UART_RX_PARITY_EN
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255, 8'd1};
`else
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd255, 8'd1};
`endif
    rx_ready = 1'b1;
    status_log.delete();
    rec_en = 1'b1;
    v0 = valid_cycles;
    sb_q.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, exp_par(8'hA5), 1'b1);
    wait_ticks(4);
    rec_en = 1'b0;
    wait_drain("basic");
    checks++;
    if (valid_cycles - v0 != 1) begin
      errors++;
      $display("FAIL basic_valid_width: got %0d cycles, required 1", valid_cycles - v0);
    end
    bad = (status_log.size() != exp_seq.size());
    s = "";
    foreach (status_log[i]) begin
      s = {s, $sformatf("%0d ", status_log[i])};
      if (!bad && status_log[i] != exp_seq[i]) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL basic_status_seq: got %s, required 1 2 3 (4) 5 255 1", s); end
  endtask

  task automatic test_false_start();
    int   v0;
    logic saw_start;
    status_log.delete();
    rec_en = 1'b1;
    v0 = valid_cycles;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    rec_en = 1'b0;
    saw_start = 1'b0;
    foreach (status_log[i]) if (status_log[i] == 8'd2) saw_start = 1'b1;
    checks++;
    if (!saw_start) begin errors++; $display("FAIL glitch_start_seen: got 0, required START (2) visited"); end
    checks++;
    if (valid_cycles != v0) begin errors++; $display("FAIL glitch_no_valid: got %0d valid cycles, required 0", valid_cycles - v0); end
    checks++;
    if (status !== 8'd1) begin errors++; $display("FAIL glitch_idle: got %0d, required 1", status); end
  endtask

  task automatic test_enable_gate();
    int v0;
    enable = 1'b0;
    repeat (4) @(posedge main_clk);
    #1;
    status_log.delete();
    rec_en = 1'b1;
    v0 = valid_cycles;
    send_frame(8'h81, exp_par(8'h81), 1'b1);
    wait_ticks(8);
    rec_en = 1'b0;
    checks++;
    if (valid_cycles != v0 || status_log.size() != 1) begin
      errors++;
      $display("FAIL enable_gate: got %0d valid cycles / %0d states, required 0 / 1", valid_cycles - v0, status_log.size());
    end
    enable = 1'b1;
    repeat (4) @(posedge main_clk);
    #1;
  endtask

  task automatic test_frame_error();
    int v1;
    rx_ready = 1'b1;
    sb_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, exp_par(8'h3C), 1'b0);
    wait_ticks(40);
    wait_drain("frame_err");
    checks++;
    if (status !== 8'd6) begin errors++; $display("FAIL break_wait_status: got %0d, required 6", status); end
    checks++;
    if (frame_err !== 1'b1 || rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL frame_err_held: got fe=%b data=%h, required fe=1 data=3c", frame_err, rx_data);
    end
    v1 = valid_cycles;
    rx = 1'b1;
    wait_ticks(4);
    checks++;
    if (status !== 8'd1) begin errors++; $display("FAIL break_release: got %0d, required 1", status); end
    checks++;
    if (valid_cycles != v1) begin errors++; $display("FAIL break_no_second_frame: got %0d valid cycles, required 0", valid_cycles - v1); end
  endtask

  task automatic test_back_to_back();
    int o0;
    rx_ready = 1'b0;
    o0 = overrun_cnt;
    sb_q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, exp_par(8'h11), 1'b1);
    sb_q.push_back('{8'h22, 1'b0, 1'b0});
    send_frame(8'h22, exp_par(8'h22), 1'b1);
    wait_ticks(4);
    checks++;
    if (overrun_cnt - o0 != 1) begin errors++; $display("FAIL overrun_pulses: got %0d, required 1", overrun_cnt - o0); end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b data=%h, required valid=1 data=22", rx_valid, rx_data);
    end
    checks++;
    if (sb_q.size() != 1) begin errors++; $display("FAIL overrun_pending: got %0d words, required 1", sb_q.size()); end
    rx_ready = 1'b1;
    repeat (2) @(posedge main_clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_release: got valid=%b, required 0", rx_valid); end
    wait_drain("back_to_back");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b1;
    sb_q.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(8'h07, 1'b0, 1'b1);
    wait_drain("parity_bad");
    sb_q.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("parity_good");
  endtask
`endif

  task automatic test_reset_mid_frame();
    int v0;
    logic [7:0] d;
    d = 8'h77;
    rx_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    wait_ticks(8);
    checks++;
    if (status !== 8'd3) begin errors++; $display("FAIL mid_frame_status: got %0d, required 3", status); end
    areset = 1'b1;
    rx     = 1'b1;
    repeat (2) @(posedge main_clk);
    #1;
    checks++;
    if (status !== 8'd1 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_state: got status=%0d data=%h, required 1 00", status, rx_data);
    end
    checks++;
    if ({rx_valid, frame_err, parity_err, overrun_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b, required 00000", {rx_valid, frame_err, parity_err, overrun_err, busy});
    end
    areset = 1'b0;
    wait_ticks(20);
    v0 = valid_cycles;
    sb_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, exp_par(8'h5A), 1'b1);
    wait_drain("after_reset");
    checks++;
    if (valid_cycles - v0 != 1) begin errors++; $display("FAIL after_reset_valid: got %0d cycles, required 1", valid_cycles - v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_enable_gate();
    test_frame_error();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
